inst_issuer: RTL and testbench

- Producer side of the control unit's instruction/flag handshake.
- Buffers instructions written by the host/DMA side in a circular FIFO.
- Presents the head instruction to the control unit and pops it on every clock edge where the control unit raises its ready flag.
- When nothing is issuable, drives an IDLE instruction so the control unit stays in single-cycle IDLE.

---
 rtl/inst_issuer.sv | 104 ++++++++++
 tb/tb_inst_issuer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/inst_issuer.sv
// inst_issuer: producer side of the control-unit instruction/flag handshake
//
// Buffers host/DMA instructions in a circular FIFO and presents the head
// word to the control unit. The head is popped on every edge where the
// control unit raises cu_flag while RUN. When nothing is issuable, the
// block drives the idle word {IDLE_OPCODE, zeros}.
//
// Ports:
//   clk, reset_n         clock (rising edge), async active-low reset
//   start, stop          pulses: begin / pause issuing (stop wins)
//   clear                sync flush of pointers, count and overflow
//   wr_en, wr_inst       enqueue strobe and word
//   full, empty, count   occupancy status
//   overflow             sticky: a write was dropped while full
//   cu_flag              control unit ready; samples instruction this edge
//   instruction          word presented to the control unit
//   busy, done           state is RUN / one-cycle pulse when RUN drained
//
// Optional build macro INST_ISSUER_STATS_EN adds issued_cnt (wrapping pop
// count) and stall_cnt (saturating RUN-with-data-but-not-ready cycles).
module inst_issuer #(
  parameter int INST_BITS   = 16,
  parameter int OPCODE_BITS = 4,
  parameter int IDLE_OPCODE = 0,
  parameter int DEPTH       = 16,
  parameter int CNT_BITS    = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [INST_BITS-1:0] wr_inst,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_BITS-1:0]  count,
  output logic                 overflow,
  input  logic                 cu_flag,
  output logic [INST_BITS-1:0] instruction,
`ifdef INST_ISSUER_STATS_EN
  output logic [15:0]          issued_cnt,
  output logic [15:0]          stall_cnt,
`endif
  output logic                 busy,
  output logic                 done
);
  localparam int PTR_BITS = CNT_BITS - 1;
  localparam logic [INST_BITS-1:0] IDLE_WORD =
    {OPCODE_BITS'(IDLE_OPCODE), (INST_BITS - OPCODE_BITS)'(0)};
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [PTR_BITS-1:0] rd_ptr, wr_ptr;
  logic [INST_BITS-1:0] mem [DEPTH];
  logic run, pop, push, drain;
  assign run = state == RUN;
  assign full = count == CNT_BITS'(DEPTH);
  assign empty = count == '0;
  assign busy = run;
  assign pop = run && !empty && cu_flag;
  // a full FIFO never accepts a write, even if the head pops on the same edge
  assign push = wr_en && !full;
  // a simultaneous push keeps the FIFO non-empty, so it is not a drain
  assign drain = pop && !push && count == CNT_BITS'(1);
  assign instruction = (run && !empty) ? mem[rd_ptr] : IDLE_WORD;
  always_ff @(posedge clk)
    if (push && !clear) mem[wr_ptr] <= wr_inst;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else if (clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_BITS'(push) - CNT_BITS'(pop);
      if (wr_en && full) overflow <= 1'b1;
      if (stop || drain) state <= IDLE;
      else if (start) state <= RUN;
      done <= drain;
    end
`ifdef INST_ISSUER_STATS_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      issued_cnt <= '0;
      stall_cnt  <= '0;
    end else if (clear) begin
      issued_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (pop) issued_cnt <= issued_cnt + 1'b1;
      if (run && !empty && !cu_flag && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_inst_issuer.sv
// tb_inst_issuer: directed self-checking bench for inst_issuer
module tb_inst_issuer;
  logic clk = 1'b0;
  logic reset_n, start, stop, clear, wr_en, cu_flag;
  logic [15:0] wr_inst, instruction;
  logic full, empty, overflow, busy, done;
  logic [4:0] count;
`ifdef INST_ISSUER_STATS_EN
  logic [15:0] issued_cnt, stall_cnt;
`endif
  int total = 0;
  int bad = 0;
  inst_issuer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
    .wr_en(wr_en), .wr_inst(wr_inst), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .cu_flag(cu_flag), .instruction(instruction),
`ifdef INST_ISSUER_STATS_EN
    .issued_cnt(issued_cnt), .stall_cnt(stall_cnt),
`endif
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [15:0] w);
    wr_en = 1'b1;
    wr_inst = w;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic test_reset();
    reset_n = 1'b0; start = 0; stop = 0; clear = 0; wr_en = 0; cu_flag = 0; wr_inst = '0;
    #3;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (instruction !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h want=0000", instruction); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask
  task automatic test_basic();
    logic [15:0] exp [3] = '{16'h1123, 16'h2456, 16'h3789};
    for (int i = 0; i < 3; i++) push(exp[i]);
    total++; if (count !== 5'd3) begin bad++; $display("FAIL basic_count got=%0d want=3", count); end
    total++; if (instruction !== 16'h0000) begin bad++; $display("FAIL basic_idle_instr got=%h want=0000", instruction); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b want=0", busy); end
    cu_flag = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (instruction !== exp[i]) begin bad++; $display("FAIL basic_issue%0d got=%h want=%h", i, instruction, exp[i]); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_early_done%0d got=%b want=0", i, done); end
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b want=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    total++; if (instruction !== 16'h0000) begin bad++; $display("FAIL basic_instr_after got=%h want=0000", instruction); end
    cu_flag = 1'b0;
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", done); end
  endtask
  task automatic test_stall();
    push(16'h1123); push(16'h2456);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (instruction !== 16'h1123) begin bad++; $display("FAIL stall_head%0d got=%h want=1123", i, instruction); end
      total++; if (count !== 5'd2) begin bad++; $display("FAIL stall_count%0d got=%0d want=2", i, count); end
      tick();
    end
    cu_flag = 1'b1;
    tick();
    total++; if (instruction !== 16'h2456) begin bad++; $display("FAIL stall_resume got=%h want=2456", instruction); end
    total++; if (count !== 5'd1) begin bad++; $display("FAIL stall_resume_count got=%0d want=1", count); end
    tick();
    cu_flag = 1'b0;
    total++; if (done !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL stall_drain got done=%b count=%0d want done=1 count=0", done, count); end
    tick();
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 16; i++) push(16'h5000 + 16'(i));
    total++; if (full !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL ovf_full got full=%b count=%0d want full=1 count=16", full, count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", overflow); end
    push(16'h5010);
    total++; if (overflow !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL ovf_drop got ovf=%b count=%0d want ovf=1 count=16", overflow, count); end
    cu_flag = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++; if (instruction !== 16'h5000 + 16'(i)) begin bad++; $display("FAIL ovf_drain%0d got=%h want=%h", i, instruction, 16'h5000 + 16'(i)); end
      tick();
    end
    cu_flag = 1'b0;
    total++; if (empty !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL ovf_empty got empty=%b done=%b want 1 1", empty, done); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
  endtask
  task automatic test_simul();
    push(16'hA001);
    start = 1'b1;
    tick();
    start = 1'b0;
    cu_flag = 1'b1; wr_en = 1'b1; wr_inst = 16'hA002;
    tick();
    wr_en = 1'b0;
    total++; if (count !== 5'd1) begin bad++; $display("FAIL simul_count got=%0d want=1", count); end
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL simul_state got done=%b busy=%b want done=0 busy=1", done, busy); end
    total++; if (instruction !== 16'hA002) begin bad++; $display("FAIL simul_next got=%h want=a002", instruction); end
    tick();
    cu_flag = 1'b0;
    total++; if (done !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL simul_drain got done=%b count=%0d want 1 0", done, count); end
    tick();
  endtask
  task automatic test_start_stop();
    push(16'hB001);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    total++; if (busy !== 1'b0 || instruction !== 16'h0000) begin bad++; $display("FAIL startstop_idle got busy=%b instr=%h want 0 0000", busy, instruction); end
    start = 1'b1;
    tick();
    start = 1'b0; stop = 1'b1; cu_flag = 1'b1;
    tick();
    stop = 1'b0; cu_flag = 1'b0;
    total++; if (busy !== 1'b0 || count !== 5'd0) begin bad++; $display("FAIL stop_pop got busy=%b count=%0d want 0 0", busy, count); end
  endtask
  task automatic test_reset_mid();
    push(16'hC001); push(16'hC002);
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (instruction !== 16'hC001 || busy !== 1'b1) begin bad++; $display("FAIL mid_run got instr=%h busy=%b want c001 1", instruction, busy); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (instruction !== 16'h0000) begin bad++; $display("FAIL mid_instr got=%h want=0000", instruction); end
    total++; if (count !== 5'd0 || busy !== 1'b0) begin bad++; $display("FAIL mid_state got count=%0d busy=%b want 0 0", count, busy); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask
`ifdef INST_ISSUER_STATS_EN
  task automatic test_stats();
    for (int i = 0; i < 5; i++) push(16'hD000 + 16'(i));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    cu_flag = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    cu_flag = 1'b0;
    total++; if (issued_cnt !== 16'd5) begin bad++; $display("FAIL stats_issued got=%0d want=5", issued_cnt); end
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL stats_stall got=%0d want=3", stall_cnt); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (issued_cnt !== 16'd0 || stall_cnt !== 16'd0) begin bad++; $display("FAIL stats_clear got=%0d/%0d want=0/0", issued_cnt, stall_cnt); end
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_simul();
    test_start_stop();
    test_reset_mid();
`ifdef INST_ISSUER_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
